regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates that port between two sources: the in-order pipeline writeback stage, and a long-latency unit (LU) such as a multiply/divide unit or a slow load.
- Keeps a per-register busy scoreboard for destinations issued to the LU.
- Produces the decode-stage hazard stall and a starvation stall that lets a waiting LU result drain.

Parameters:
- WAIT_MAX, 4, cycles a held LU result may wait before the pipeline is frozen for one cycle (legal range 1..15).
- CNT_W, 4, width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- wb_valid  input  1  pipeline writeback requests a write this cycle; cannot be back-pressured
- wb_rd  input  5  pipeline destination register
- wb_data  input  32  pipeline write data
- lu_valid  input  1  LU result available
- lu_rd  input  5  LU destination register
- lu_data  input  32  LU result
- lu_ready  output  1  arbiter accepts the LU result this cycle
- issue_valid  input  1  decode issues an instruction to the LU this cycle
- issue_rd  input  5  destination of that LU instruction
- dec_rs1  input  5  decode-stage source register 1
- dec_rs2  input  5  decode-stage source register 2
- dec_rd  input  5  decode-stage destination register
- RegWrite  output  1  register-file write enable
- write_register  output  5  register-file write address
- write_data  output  32  register-file write data
- hazard_stall  output  1  decode must stall
- drain_stall  output  1  pipeline must insert a bubble so the LU result can drain
- busy_mask  output  32  scoreboard state, for debug

Behaviour:
- Reset state, applied while reset is low at a clk edge:
  - hold_valid=0, busy_mask=0, wait_cnt=0.
  - lu_ready=0 while reset is low.
  - RegWrite=0, hazard_stall=0, drain_stall=0.
- Hold register (one entry):
  - lu_ready = !hold_valid.
  - When lu_valid && lu_ready, capture lu_rd/lu_data into the hold register; hold_valid=1 from the next cycle.
  - The LU result is never written to the register file in the cycle it is accepted. Minimum latency from acceptance to write is 1 cycle.
- Write-port grant (combinational, zero latency to the write port):
  - wb_valid=1: RegWrite=1, write_register=wb_rd, write_data=wb_data. The pipeline always wins.
  - Otherwise, if hold_valid=1: RegWrite=1 with the held rd/data. hold_valid clears at the clock edge.
  - Otherwise: RegWrite=0, write_register=0, write_data=0.
  - A write to rd=0 is still presented on the port; the register file ignores it.
- Hold drain and re-accept: a drain and a new LU acceptance never occur in the same cycle, because lu_ready is low while holding.
- Wait counter:
  - Increments each cycle that hold_valid=1 and wb_valid=1 (hold result denied); saturates at WAIT_MAX.
  - Clears when the hold register drains.
  - drain_stall = (wait_cnt==WAIT_MAX) && hold_valid, registered-free (combinational from state).
  - The pipeline then guarantees wb_valid=0 in the following cycle, so the drain occurs.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd].
  - Clear: a hold drain clears busy[hold_rd].
  - Same-rd set and clear in one cycle: set wins.
  - busy[0] is always 0.
- Hazard stall:
  - Define eff_busy = busy_mask with the bit being cleared this cycle masked off. The register file forwards same-cycle writes, so the stall releases in the drain cycle.
  - hazard_stall = eff_busy[dec_rs1] | eff_busy[dec_rs2] | eff_busy[dec_rd]. The dec_rd term covers write-after-write.
- Reset asserted mid-operation: the held result is discarded and busy bits are cleared. Upstream is flushed by the same reset.

Decomposition:
- Shared package (cpu_pkg): REG_ADDR_W=5, XLEN=32, NUM_REGS=32, WAIT_MAX default.
- One natural sub-module: regfile_scoreboard, holding the busy mask with set/clear/eff_busy and the stall compare.
- The arbiter top keeps the hold register, wait counter and grant mux.

Test Plan:
- Reset low for 2 cycles with wb_valid=1 -> RegWrite=0, lu_ready=0, busy_mask=0. After release, wb_valid=1 rd=5 data=0xA5A5A5A5 -> same-cycle RegWrite=1, write_register=5.
- issue rd=7; 3 cycles later lu_valid rd=7 data=0x1234 with wb idle -> accepted at cycle t, RegWrite=1 write_register=7 at t+1, busy[7]=0 after t+1. dec_rs1=7 shows hazard_stall=1 until t+1, where it is 0.
- Hold full and wb_valid=1 continuously, WAIT_MAX=4 -> drain_stall=1 after 4 denied cycles. The bench drops wb_valid; the hold drains, wait_cnt=0, lu_ready=1 next cycle.
- issue_valid rd=9 in the same cycle that the hold drains rd=9 -> busy[9] remains 1.
- issue_rd=0 and lu result rd=0 -> busy_mask stays 0, hazard_stall=0 for dec_rs1=0.
- Reset pulsed low while hold_valid=1 and busy[3]=1 -> hold discarded with no write to x3, busy_mask=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback request payload.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned WAIT_MAX_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy mask for long-latency destinations and the decode hazard compare.
module regfile_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic [NUM_REGS-1:0]   busy_mask_o,
    output logic                  hazard_stall_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] eff_busy;

    // Clearing bit is hidden from the compare: the regfile forwards the drain write.
    always_comb begin
        clr_mask = '0;
        if (clr_en_i) begin
            clr_mask[clr_rd_i] = 1'b1;
        end
        eff_busy = busy_q & ~clr_mask;
        busy_d   = eff_busy;
        if (set_en_i && (set_rd_i != '0)) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        hazard_stall_o = reset && (eff_busy[rs1_i] | eff_busy[rs2_i] | eff_busy[rd_i]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_mask_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, a one-entry
// hold buffer stores the long-latency result until the port is free.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  lu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] write_register,
    output logic [XLEN-1:0]       write_data,
    output logic                  hazard_stall,
    output logic                  drain_stall,
    output logic [NUM_REGS-1:0]   busy_mask
);

    wb_req_t          hold_q;
    wb_req_t          hold_d;
    logic             hold_valid_q;
    logic             hold_valid_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             accept;
    logic             drain;

    assign lu_ready    = reset && !hold_valid_q;
    assign accept      = lu_valid && lu_ready;
    assign drain_stall = reset && hold_valid_q && (wait_cnt_q == CNT_W'(WAIT_MAX));

    // Grant mux, hold drain/accept and starvation counter.
    always_comb begin
        hold_d         = hold_q;
        hold_valid_d   = hold_valid_q;
        wait_cnt_d     = wait_cnt_q;
        RegWrite       = 1'b0;
        write_register = '0;
        write_data     = '0;
        drain          = 1'b0;

        if (reset) begin
            if (wb_valid) begin
                RegWrite       = 1'b1;
                write_register = wb_rd;
                write_data     = wb_data;
            end else if (hold_valid_q) begin
                RegWrite       = 1'b1;
                write_register = hold_q.rd;
                write_data     = hold_q.data;
                drain          = 1'b1;
            end
        end

        if (drain) begin
            hold_valid_d = 1'b0;
            wait_cnt_d   = '0;
        end else if (hold_valid_q && wb_valid && (wait_cnt_q != CNT_W'(WAIT_MAX))) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        // Never coincides with drain: lu_ready is low while holding.
        if (accept) begin
            hold_d.rd    = lu_rd;
            hold_d.data  = lu_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .set_en_i       (issue_valid),
        .set_rd_i       (issue_rd),
        .clr_en_i       (drain),
        .clr_rd_i       (hold_q.rd),
        .rs1_i          (dec_rs1),
        .rs2_i          (dec_rs2),
        .rd_i           (dec_rd),
        .busy_mask_o    (busy_mask),
        .hazard_stall_o (hazard_stall)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        hazard_stall;
    logic        drain_stall;
    logic [31:0] busy_mask;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.WAIT_MAX(4), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .lu_valid       (lu_valid),
        .lu_rd          (lu_rd),
        .lu_data        (lu_data),
        .lu_ready       (lu_ready),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .hazard_stall   (hazard_stall),
        .drain_stall    (drain_stall),
        .busy_mask      (busy_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let inputs change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

        // Reset with a pending pipeline write
        tick(); tick();
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_hazard", 32'(hazard_stall), 32'd0);
        chk("rst_drain", 32'(drain_stall), 32'd0);

        reset = 1'b1; settle();
        chk("wb_regwrite", 32'(RegWrite), 32'd1);
        chk("wb_addr", 32'(write_register), 32'd5);
        chk("wb_data", write_data, 32'hA5A5A5A5);
        tick();

        // Issue rd=7, result returns three cycles later
        wb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; dec_rs1 = 5'd7; settle();
        chk("busy7_set", busy_mask, 32'h0000_0080);
        chk("raw_rs1_stall", 32'(hazard_stall), 32'd1);
        dec_rs1 = 5'd0; dec_rs2 = 5'd7; settle();
        chk("raw_rs2_stall", 32'(hazard_stall), 32'd1);
        dec_rs2 = 5'd0; dec_rd = 5'd7; settle();
        chk("waw_rd_stall", 32'(hazard_stall), 32'd1);
        dec_rd = 5'd0; dec_rs1 = 5'd7;
        tick(); tick();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_1234; settle();
        chk("accept_ready", 32'(lu_ready), 32'd1);
        chk("accept_no_write", 32'(RegWrite), 32'd0);
        chk("accept_stall", 32'(hazard_stall), 32'd1);
        tick();
        lu_valid = 1'b0; settle();
        chk("hold_not_ready", 32'(lu_ready), 32'd0);
        chk("drain_regwrite", 32'(RegWrite), 32'd1);
        chk("drain_addr", 32'(write_register), 32'd7);
        chk("drain_data", write_data, 32'h0000_1234);
        chk("drain_stall_release", 32'(hazard_stall), 32'd0);
        chk("drain_busy_still", busy_mask, 32'h0000_0080);
        tick();
        chk("after_drain_busy", busy_mask, 32'd0);
        chk("after_drain_write", 32'(RegWrite), 32'd0);
        chk("after_drain_ready", 32'(lu_ready), 32'd1);
        dec_rs1 = 5'd0;

        // Starvation: hold rd=10 while the pipeline writes every cycle
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h0000_BEEF;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0011;
        tick();
        lu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("denied%0d_drain_stall", i), 32'(drain_stall), 32'd0);
            chk($sformatf("denied%0d_addr", i), 32'(write_register), 32'd1);
            tick();
        end
        settle();
        chk("starved_drain_stall", 32'(drain_stall), 32'd1);
        wb_valid = 1'b0; settle();
        chk("starve_drain_addr", 32'(write_register), 32'd10);
        chk("starve_drain_data", write_data, 32'h0000_BEEF);
        chk("starve_drain_stall_hold", 32'(drain_stall), 32'd1);
        tick();
        chk("starve_after_stall", 32'(drain_stall), 32'd0);
        chk("starve_after_ready", 32'(lu_ready), 32'd1);
        chk("starve_after_busy", busy_mask, 32'd0);

        // Set and clear of rd=9 in the same cycle: set wins
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_0099;
        tick();
        lu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9; dec_rs1 = 5'd9; settle();
        chk("setclr_wait_cleared", 32'(drain_stall), 32'd0);
        chk("setclr_addr", 32'(write_register), 32'd9);
        chk("setclr_hazard", 32'(hazard_stall), 32'd0);
        tick();
        issue_valid = 1'b0; settle();
        chk("setclr_busy9", busy_mask, 32'h0000_0200);
        chk("setclr_reissue_stall", 32'(hazard_stall), 32'd1);
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_0999;
        tick();
        lu_valid = 1'b0;
        tick();
        chk("setclr_final_busy", busy_mask, 32'd0);
        dec_rs1 = 5'd0;

        // Destination x0 never marks busy but is still written
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        chk("x0_busy", busy_mask, 32'd0);
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h0000_0055;
        tick();
        lu_valid = 1'b0; settle();
        chk("x0_regwrite", 32'(RegWrite), 32'd1);
        chk("x0_addr", 32'(write_register), 32'd0);
        chk("x0_data", write_data, 32'h0000_0055);
        chk("x0_hazard", 32'(hazard_stall), 32'd0);
        tick();
        chk("x0_after_busy", busy_mask, 32'd0);

        // Reset while holding rd=3 discards the result
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h0000_0333;
        tick();
        lu_valid = 1'b0; reset = 1'b0; dec_rs1 = 5'd3; settle();
        chk("midrst_no_write", 32'(RegWrite), 32'd0);
        chk("midrst_lu_ready", 32'(lu_ready), 32'd0);
        tick();
        reset = 1'b1; settle();
        chk("postrst_no_write", 32'(RegWrite), 32'd0);
        chk("postrst_busy", busy_mask, 32'd0);
        chk("postrst_ready", 32'(lu_ready), 32'd1);
        chk("postrst_hazard", 32'(hazard_stall), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
